// File: rtl/correlation_pair_sequencer_if.sv
// Bundle between the pair sequencer and its controller/logger/DUT-side harness.
// The sequencer takes the slave modport; whoever launches runs and consumes results takes master.
interface correlation_pair_sequencer_if #(
    parameter int WIDTH = 5
);
    logic                   start;
    logic                   mode;
    logic [2*WIDTH-1:0]     seed;
    logic [2*WIDTH:0]       num_pairs;
    logic                   dut_y;
    logic                   log_ready;
    logic [WIDTH-1:0]       vec;
    logic                   phase;
    logic                   pair_start;
    logic                   pair_valid;
    logic [2*WIDTH-1:0]     pair_idx;
    logic [7:0]             toggle_cnt;
    logic                   y_final;
    logic                   busy;
    logic                   done;

    modport master (
        output start, mode, seed, num_pairs, dut_y, log_ready,
        input  vec, phase, pair_start, pair_valid, pair_idx, toggle_cnt, y_final, busy, done
    );

    modport slave (
        input  start, mode, seed, num_pairs, dut_y, log_ready,
        output vec, phase, pair_start, pair_valid, pair_idx, toggle_cnt, y_final, busy, done
    );
endinterface

// File: rtl/correlation_pair_sequencer.sv
// Transition-pair stimulus sequencer: drives init/final vectors, counts DUT output toggles
// during the final phase and hands one result per pair to a logger.
//
// state  | meaning
// IDLE   | vec=0, waiting for start
// INIT   | initial vector held for HOLD cycles
// FINAL  | final vector held for HOLD cycles, dut_y sampled
// REPORT | result presented until logger accepts
// DONE   | one-cycle done pulse, then IDLE
module correlation_pair_sequencer #(
    parameter int WIDTH = 5,
    parameter int HOLD  = 4
) (
    input  logic clk,
    input  logic rst_n,
    correlation_pair_sequencer_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
    // Tap exponents e map to mask bit e-1.
    localparam logic [15:0] TAP_MASK =
        (PW == 4)  ? 16'h000C :
        (PW == 6)  ? 16'h0030 :
        (PW == 8)  ? 16'h00B8 :
        (PW == 10) ? 16'h0240 :
        (PW == 12) ? 16'h0829 :
        (PW == 14) ? 16'h2015 : 16'hD008;

    typedef enum logic [2:0] {IDLE, INIT, FINAL, REPORT, DONE} state_t;

    state_t        state;
    logic [PW-1:0] pair;
    logic [PW:0]   remaining;
    logic          lfsr_mode;
    logic [7:0]    timer;
    logic          y_prev;

    logic [15:0]   pair_ext;
    logic          feedback;
    logic [PW-1:0] next_pair;
    logic [PW-1:0] first_pair;
    logic          last_pair;

    always_comb begin
        pair_ext   = 16'(pair);
        feedback   = ^(pair_ext & TAP_MASK);
        next_pair  = lfsr_mode ? {pair[PW-2:0], feedback} : pair + 1'b1;
        // Exhaustive runs end on the all-ones pair so the counter wrap never produces an extra pair.
        last_pair  = lfsr_mode ? (remaining == (PW+1)'(1)) : (&pair);
        first_pair = '0;
        if (bus.mode)
            first_pair = (bus.seed == '0) ? PW'(1) : bus.seed;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pair           <= '0;
            remaining      <= '0;
            lfsr_mode      <= 1'b0;
            timer          <= '0;
            y_prev         <= 1'b0;
            bus.vec        <= '0;
            bus.phase      <= 1'b0;
            bus.pair_start <= 1'b0;
            bus.pair_valid <= 1'b0;
            bus.pair_idx   <= '0;
            bus.toggle_cnt <= '0;
            bus.y_final    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.pair_start <= 1'b0;
            bus.done       <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.vec   <= '0;
                    bus.phase <= 1'b0;
                    bus.busy  <= 1'b0;
                    if (bus.start) begin
                        lfsr_mode <= bus.mode;
                        remaining <= bus.num_pairs;
                        if (bus.mode && (bus.num_pairs == '0)) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            pair           <= first_pair;
                            state          <= INIT;
                            timer          <= HOLD_M1;
                            bus.vec        <= first_pair[PW-1:WIDTH];
                            bus.pair_start <= 1'b1;
                            bus.busy       <= 1'b1;
                            bus.toggle_cnt <= '0;
                        end
                    end
                end
                INIT: begin
                    y_prev <= bus.dut_y;
                    if (timer == '0) begin
                        state     <= FINAL;
                        timer     <= HOLD_M1;
                        bus.vec   <= pair[WIDTH-1:0];
                        bus.phase <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                FINAL: begin
                    y_prev      <= bus.dut_y;
                    bus.y_final <= bus.dut_y;
                    if ((bus.dut_y != y_prev) && (bus.toggle_cnt != 8'hFF))
                        bus.toggle_cnt <= bus.toggle_cnt + 1'b1;
                    if (timer == '0) begin
                        state          <= REPORT;
                        bus.pair_valid <= 1'b1;
                        bus.pair_idx   <= pair;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.log_ready) begin
                        bus.pair_valid <= 1'b0;
                        if (last_pair) begin
                            state     <= DONE;
                            bus.done  <= 1'b1;
                            bus.busy  <= 1'b0;
                            bus.vec   <= '0;
                            bus.phase <= 1'b0;
                        end else begin
                            pair           <= next_pair;
                            remaining      <= remaining - 1'b1;
                            state          <= INIT;
                            timer          <= HOLD_M1;
                            bus.vec        <= next_pair[PW-1:WIDTH];
                            bus.phase      <= 1'b0;
                            bus.pair_start <= 1'b1;
                            bus.toggle_cnt <= '0;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    bus.vec   <= '0;
                    bus.phase <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_correlation_pair_sequencer.sv
// Bench for correlation_pair_sequencer: three instances (HOLD 2, 3, 255) at WIDTH=2,
// results checked against a scoreboard of expected pair results.
module tb_correlation_pair_sequencer;
    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] tog;
        logic       yf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic [3:0] seed = '0;
    logic [4:0] num_pairs = '0;
    logic log_ready = 1'b1;
    logic tgl = 1'b0;
    int   sel = 0;

    int n_checks = 0;
    int n_pass = 0;

    res_t exp_q[$];
    res_t obs_q[$];
    logic [2:0] obs_vec[$];
    logic       obs_ps[$];
    logic [1:0] stall_vec;

    correlation_pair_sequencer_if #(.WIDTH(2)) ifa ();
    correlation_pair_sequencer_if #(.WIDTH(2)) ifb ();
    correlation_pair_sequencer_if #(.WIDTH(2)) ifc ();

    correlation_pair_sequencer #(.WIDTH(2), .HOLD(2))   dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    correlation_pair_sequencer #(.WIDTH(2), .HOLD(3))   dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    correlation_pair_sequencer #(.WIDTH(2), .HOLD(255)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    always #5 clk = ~clk;
    always @(posedge clk) tgl <= ~tgl;

    assign ifa.start = start & (sel == 0);
    assign ifb.start = start & (sel == 1);
    assign ifc.start = start & (sel == 2);
    assign ifa.mode = mode;  assign ifb.mode = mode;  assign ifc.mode = mode;
    assign ifa.seed = seed;  assign ifb.seed = seed;  assign ifc.seed = seed;
    assign ifa.num_pairs = num_pairs;  assign ifb.num_pairs = num_pairs;  assign ifc.num_pairs = num_pairs;
    assign ifa.log_ready = log_ready;  assign ifb.log_ready = log_ready;  assign ifc.log_ready = log_ready;
    assign ifa.dut_y = ~ifa.vec[0];
    assign ifb.dut_y = ~ifb.vec[0];
    assign ifc.dut_y = tgl;

    // Packed view {vec, phase, pair_start, pair_valid, pair_idx, toggle_cnt, y_final, busy, done}.
    logic [19:0] pk_a, pk_b, pk_c, pk;
    assign pk_a = {ifa.vec, ifa.phase, ifa.pair_start, ifa.pair_valid, ifa.pair_idx, ifa.toggle_cnt, ifa.y_final, ifa.busy, ifa.done};
    assign pk_b = {ifb.vec, ifb.phase, ifb.pair_start, ifb.pair_valid, ifb.pair_idx, ifb.toggle_cnt, ifb.y_final, ifb.busy, ifb.done};
    assign pk_c = {ifc.vec, ifc.phase, ifc.pair_start, ifc.pair_valid, ifc.pair_idx, ifc.toggle_cnt, ifc.y_final, ifc.busy, ifc.done};
    assign pk = (sel == 1) ? pk_b : (sel == 2) ? pk_c : pk_a;

    logic [1:0] m_vec;
    logic       m_phase, m_ps, m_valid, m_yf, m_busy, m_done;
    logic [3:0] m_idx;
    logic [7:0] m_tog;
    assign {m_vec, m_phase, m_ps, m_valid, m_idx, m_tog, m_yf, m_busy, m_done} = pk;

    function automatic res_t model_res(input logic [3:0] idx);
        res_t r;
        r.idx = idx;
        r.tog = (idx[2] != idx[0]) ? 8'd1 : 8'd0;
        r.yf  = ~idx[0];
        return r;
    endfunction

    task automatic launch(input int which, input logic md, input logic [3:0] sd, input logic [4:0] np);
        @(negedge clk);
        sel = which; mode = md; seed = sd; num_pairs = np; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Records results, per-cycle vec/phase/pair_start and optionally holds log_ready low on one pair.
    task automatic run_capture(input int budget, input int stall_idx, input int stall_len,
                               output int done_cyc, output int busy_cnt, output int busy_last, output bit stable);
        int stalled = 0;
        logic [3:0] held_idx = '0;
        done_cyc = -1; busy_cnt = 0; busy_last = 0; stable = 1'b1;
        obs_q.delete(); obs_vec.delete(); obs_ps.delete();
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            obs_vec.push_back({m_phase, m_vec});
            obs_ps.push_back(m_ps);
            if (m_busy) begin busy_cnt++; busy_last = c; end
            if (m_done) begin done_cyc = c; break; end
            if (m_valid && (32'(m_idx) == stall_idx) && (stalled < stall_len)) begin
                if (stalled == 0) begin held_idx = m_idx; stall_vec = m_vec; end
                else if (m_idx !== held_idx || m_vec !== stall_vec) stable = 1'b0;
                stalled++;
                log_ready = 1'b0;
            end else begin
                log_ready = 1'b1;
                if (m_valid) obs_q.push_back({m_idx, m_tog, m_yf});
            end
        end
        log_ready = 1'b1;
    endtask

    task automatic test_reset;
        n_checks++;
        if (pk_a !== 20'd0) $display("FAIL reset_a outputs got %h want 0", pk_a); else n_pass++;
        n_checks++;
        if (pk_b !== 20'd0) $display("FAIL reset_b outputs got %h want 0", pk_b); else n_pass++;
    endtask

    task automatic test_exhaustive;
        int dc, bc, bl; bit st; res_t e, o;
        for (int i = 0; i < 16; i++) exp_q.push_back(model_res(4'(i)));
        launch(0, 1'b0, 4'd0, 5'd0);
        run_capture(200, -1, 0, dc, bc, bl, st);
        n_checks++; if (obs_q.size() != 16) $display("FAIL exh_count got %0d want 16", obs_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL exh_result missing want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL exh_result got %h want %h", o, e); else n_pass++;
            end
        end
        n_checks++; if (dc != 81) $display("FAIL exh_done_cycle got %0d want 81", dc); else n_pass++;
        n_checks++; if (bc != 80 || bl != 80) $display("FAIL exh_busy got %0d/%0d want 80/80", bc, bl); else n_pass++;
        if (obs_vec.size() > 32) begin
            n_checks++; if (obs_vec[30] !== 3'b001) $display("FAIL pair6_init got %b want 001", obs_vec[30]); else n_pass++;
            n_checks++; if (obs_vec[32] !== 3'b110) $display("FAIL pair6_final got %b want 110", obs_vec[32]); else n_pass++;
            n_checks++; if (obs_ps[30] !== 1'b1 || obs_ps[31] !== 1'b0) $display("FAIL pair6_start got %b%b want 10", obs_ps[30], obs_ps[31]); else n_pass++;
        end else begin
            n_checks++; $display("FAIL exh_trace short got %0d cycles want >32", obs_vec.size());
        end
    endtask

    task automatic test_stall;
        int dc, bc, bl; bit st; res_t e, o;
        for (int i = 0; i < 16; i++) exp_q.push_back(model_res(4'(i)));
        launch(0, 1'b0, 4'd0, 5'd0);
        run_capture(200, 3, 10, dc, bc, bl, st);
        n_checks++; if (!st) $display("FAIL stall_stable got unstable want stable"); else n_pass++;
        n_checks++; if (stall_vec !== 2'd3) $display("FAIL stall_vec got %0d want 3", stall_vec); else n_pass++;
        n_checks++; if (obs_q.size() != 16) $display("FAIL stall_count got %0d want 16", obs_q.size()); else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL stall_result missing want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL stall_result got %h want %h", o, e); else n_pass++;
            end
        end
        n_checks++; if (dc != 91) $display("FAIL stall_done_cycle got %0d want 91", dc); else n_pass++;
    endtask

    task automatic test_toggle;
        int dc, bc, bl; bit st; res_t e, o;
        for (int i = 0; i < 16; i++) exp_q.push_back(model_res(4'(i)));
        launch(1, 1'b0, 4'd0, 5'd0);
        run_capture(300, -1, 0, dc, bc, bl, st);
        n_checks++; if (obs_q.size() != 16) $display("FAIL tog_count got %0d want 16", obs_q.size()); else n_pass++;
        if (obs_q.size() == 16) begin
            n_checks++; if (obs_q[6] !== {4'd6, 8'd1, 1'b1}) $display("FAIL tog_pair_1to2 got %h want %h", obs_q[6], {4'd6, 8'd1, 1'b1}); else n_pass++;
            n_checks++; if (obs_q[5].tog !== 8'd0) $display("FAIL tog_pair_1to1 got %0d want 0", obs_q[5].tog); else n_pass++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL tog_result missing want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL tog_result got %h want %h", o, e); else n_pass++;
            end
        end
        n_checks++; if (dc != 113) $display("FAIL tog_done_cycle got %0d want 113", dc); else n_pass++;
    endtask

    task automatic test_saturation;
        int dc, bc, bl; bit st;
        launch(2, 1'b1, 4'd0, 5'd1);
        run_capture(700, -1, 0, dc, bc, bl, st);
        n_checks++; if (obs_q.size() != 1) $display("FAIL sat_count got %0d want 1", obs_q.size()); else n_pass++;
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0].tog !== 8'd255) $display("FAIL sat_toggle got %0d want 255", obs_q[0].tog); else n_pass++;
            n_checks++; if (obs_q[0].idx !== 4'd1) $display("FAIL sat_idx got %0d want 1", obs_q[0].idx); else n_pass++;
        end
        n_checks++; if (dc != 512) $display("FAIL sat_done_cycle got %0d want 512", dc); else n_pass++;
    endtask

    task automatic test_lfsr;
        int dc, bc, bl; bit st; res_t e, o;
        logic [3:0] s = 4'd1;
        bit seen[16];
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(model_res(s));
            s = {s[2:0], s[3] ^ s[2]};
        end
        launch(0, 1'b1, 4'd0, 5'd15);
        run_capture(200, -1, 0, dc, bc, bl, st);
        n_checks++; if (obs_q.size() != 15) $display("FAIL lfsr_count got %0d want 15", obs_q.size()); else n_pass++;
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0].idx !== 4'd1) $display("FAIL lfsr_first got %0d want 1", obs_q[0].idx); else n_pass++;
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].idx == 4'd0 || seen[obs_q[i].idx]) $display("FAIL lfsr_distinct got %0d at %0d want new nonzero", obs_q[i].idx, i);
            else n_pass++;
            seen[obs_q[i].idx] = 1'b1;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL lfsr_result missing want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL lfsr_result got %h want %h", o, e); else n_pass++;
            end
        end
        n_checks++; if (dc != 76) $display("FAIL lfsr_done_cycle got %0d want 76", dc); else n_pass++;
    endtask

    task automatic test_lfsr_zero;
        int dc, bc, bl; bit st;
        launch(0, 1'b1, 4'd5, 5'd0);
        run_capture(20, -1, 0, dc, bc, bl, st);
        n_checks++; if (dc != 1) $display("FAIL zero_done_cycle got %0d want 1", dc); else n_pass++;
        n_checks++; if (obs_q.size() != 0 || bc != 0) $display("FAIL zero_activity got %0d results %0d busy want 0/0", obs_q.size(), bc); else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int dc, bc, bl; bit st;
        launch(0, 1'b0, 4'd0, 5'd0);
        for (int c = 1; c <= 13; c++) @(negedge clk);
        n_checks++; if (m_phase !== 1'b1 || m_busy !== 1'b1) $display("FAIL mid_in_final got %b%b want 11", m_phase, m_busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (pk_a !== 20'd0) $display("FAIL mid_reset_outputs got %h want 0", pk_a); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        launch(0, 1'b0, 4'd0, 5'd0);
        run_capture(200, -1, 0, dc, bc, bl, st);
        n_checks++; if (obs_q.size() != 16) $display("FAIL restart_count got %0d want 16", obs_q.size()); else n_pass++;
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0].idx !== 4'd0) $display("FAIL restart_first got %0d want 0", obs_q[0].idx); else n_pass++;
        end
        n_checks++; if (dc != 81) $display("FAIL restart_done_cycle got %0d want 81", dc); else n_pass++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_exhaustive();
        test_stall();
        test_toggle();
        test_saturation();
        test_lfsr();
        test_lfsr_zero();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/correlation_pair_sequencer.md
# correlation_pair_sequencer

Synthesizable, parametrised stimulus sequencer for transition-pair correlation runs on masked gate netlists. It drives an N-bit input vector into the DUT in two phases per pair: an initial vector, then a final vector. It samples the DUT output during the final phase and reports per-pair results to a logger over a valid/ready handshake. It replaces the fixed 5-input, 32×32 exhaustive loop and adds three things: LFSR-randomised pair ordering, configurable hold time, and back-pressure from the logger.

## Interface
- WIDTH, 5, DUT input vector width; legal range 2..8
- HOLD, 4, clock cycles each phase is held; legal range 1..255
- clk  in  1  sequencer clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  launch run; sampled only in IDLE
- mode  in  1  0 = exhaustive, 1 = LFSR; sampled with start
- seed  in  2*WIDTH  LFSR seed; sampled with start
- num_pairs  in  2*WIDTH+1  pair count in LFSR mode; ignored in exhaustive mode
- dut_y  in  1  DUT output, sampled on clk
- log_ready  in  1  logger accepts result
- vec  out  WIDTH  DUT input vector ({a,b,r1,r2,q} for WIDTH=5)
- phase  out  1  0 = initial vector, 1 = final vector
- pair_start  out  1  one-cycle pulse on the first INIT cycle of each pair
- pair_valid  out  1  result valid
- pair_idx  out  2*WIDTH  {init_vec, final_vec} of the reported pair
- toggle_cnt  out  8  dut_y toggles counted during the final phase, saturating at 255
- y_final  out  1  last dut_y sample of the final phase
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of run

## Operation
- FSM states: IDLE, INIT, FINAL, REPORT, DONE.
- IDLE:
  - vec=0, phase=0, busy=0.
  - start=1 latches mode, seed and num_pairs, then moves to INIT.
  - If mode=1 and num_pairs=0, the FSM goes straight to DONE instead.
- Pair source, exhaustive mode:
  - 2*WIDTH-bit counter p runs from 0 to 2^(2*WIDTH)-1.
  - init_vec = p[2W-1:W], final_vec = p[W-1:0].
  - Ordering is init-major, matching the legacy loop.
- Pair source, LFSR mode:
  - 2*WIDTH-bit Fibonacci LFSR; shift left, with bit0 = XOR of the tap bits (1-indexed exponents).
  - Taps by length: 4:{4,3}; 6:{6,5}; 8:{8,6,5,4}; 10:{10,7}; 12:{12,6,4,1}; 14:{14,5,3,1}; 16:{16,15,13,4}.
  - seed=0 is replaced by 1.
  - The first pair uses the seed value itself; the LFSR advances once per accepted result.
  - The run ends after num_pairs results are accepted.
  - num_pairs values above 2^(2W)-1 make the sequence repeat; this is legal.
- INIT:
  - vec=init_vec, phase=0 for HOLD cycles.
  - pair_start=1 on the first cycle.
- FINAL:
  - vec=final_vec, phase=1 for HOLD cycles.
  - Each cycle, dut_y is compared with its previous-cycle sample. The first FINAL cycle compares against the last INIT sample.
  - toggle_cnt increments on each mismatch and saturates at 255.
  - toggle_cnt is cleared on entry to INIT.
- REPORT:
  - vec holds final_vec and phase=1.
  - pair_valid=1; pair_idx, toggle_cnt and y_final are stable until the handshake.
  - Handshake completes on pair_valid && log_ready.
  - Afterwards: if pairs remain, go to INIT; otherwise go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- start while busy is ignored.

## Timing
- Reset values: vec=0, phase=0, pair_start=0, pair_valid=0, pair_idx=0, toggle_cnt=0, y_final=0, busy=0, done=0. State is IDLE and the LFSR and counter are cleared.
- Reset asserted mid-run aborts immediately; there is no partial report.
- All outputs are registered.
- Start accepted at edge 0 gives:
  - INIT on cycles 1..HOLD;
  - FINAL on cycles HOLD+1..2·HOLD;
  - REPORT from cycle 2·HOLD+1.
- With log_ready held at 1, each pair takes 2·HOLD+1 cycles and the next INIT starts right after the handshake cycle.
- log_ready=0 stalls the FSM in REPORT indefinitely. The DUT vector stays at final_vec and no sampling takes place.
- done follows the last handshake by one cycle.
- In exhaustive mode, counter wrap from all-ones back to 0 marks the end of the run; there is no extra pair.

## Test plan
- WIDTH=2, HOLD=2, mode=0, log_ready=1:
  - 16 results with pair_idx 0..15 in order;
  - pair 6 drives vec=1 (phase 0) then vec=2 (phase 1);
  - done pulses at cycle 81 and busy is high for cycles 1..80.
- Stall: log_ready=0 for 10 cycles during pair 3 REPORT:
  - pair_valid, pair_idx=3 and vec stay stable throughout;
  - the run completes 10 cycles later with no result lost or duplicated.
- Toggle count: dut_y driven as ~vec[0], WIDTH=2, HOLD=3:
  - pair 1→2 reports toggle_cnt=1, y_final=1;
  - pair 1→1 reports toggle_cnt=0.
- Saturation: HOLD=255, dut_y toggled every cycle in FINAL → toggle_cnt=255, no wrap.
- LFSR: WIDTH=2, mode=1, seed=0, num_pairs=15:
  - first pair_idx=1;
  - 15 distinct nonzero pair_idx values;
  - num_pairs=0 gives done at cycle 1 with no pair_valid.
- Reset mid-FINAL: rst_n low for 1 cycle → all outputs return to reset values immediately; a new start restarts from pair 0.
